reorder_buffer: RTL

- Circular in-order retirement buffer between issue (decoder) and the renaming register file.
- Allocates one ROB tag per issued instruction and captures CDB results.
- Retires at most one instruction per cycle, driving the register file's commit reg/rob/value and misbranch inputs.
- Resolves branch mispredicts at commit and flushes itself.

---
 rtl/reorder_buffer_pkg.sv | 62 ++++++
 rtl/reorder_buffer_if.sv | 67 ++++++
 rtl/reorder_buffer_rob_ptr_wrap.sv | 11 +
 rtl/reorder_buffer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared widths, constants, entry layout and operand-lookup helper for the reorder buffer.
// Optional second write-back port: define ROB_DUAL_CDB_EN.
package reorder_buffer_pkg;

  localparam int ROB_SIZE      = 16;
  localparam int ROB_TAG_WIDTH = $clog2(ROB_SIZE);
  localparam int REG_TAG_WIDTH = 5;
  localparam int DATA_WIDTH    = 32;

  typedef logic [ROB_TAG_WIDTH-1:0] rob_tag_t;
  typedef logic [REG_TAG_WIDTH-1:0] reg_tag_t;
  typedef logic [DATA_WIDTH-1:0]    data_t;

  localparam rob_tag_t ZERO_TAG_ROB  = '0;
  localparam rob_tag_t FIRST_TAG_ROB = rob_tag_t'(1);
  localparam rob_tag_t LAST_TAG_ROB  = rob_tag_t'(ROB_SIZE - 1);
  localparam reg_tag_t ZERO_TAG_REG  = '0;
  localparam data_t    ZERO_DATA     = '0;
  localparam logic     TRUE          = 1'b1;
  localparam logic     FALSE         = 1'b0;

  typedef struct packed {
    logic     valid;
    logic     ready;
    logic     is_branch;
    logic     pred_taken;
    logic     taken;
    reg_tag_t dest;
    data_t    value;
    data_t    target;
  } rob_entry_t;

  typedef struct packed {
    logic  ready;
    data_t value;
  } query_t;

  // Write-back bypass outranks the stored slot; the ALU port outranks the LSB port.
  function automatic query_t rob_lookup(input rob_tag_t tag, input rob_entry_t slot,
                                        input logic alu_hit, input data_t alu_value,
                                        input logic lsb_hit, input data_t lsb_value);
    query_t r;
    r.ready = FALSE;
    r.value = ZERO_DATA;
    if (tag != ZERO_TAG_ROB) begin
      if (slot.ready) begin
        r.ready = TRUE;
        r.value = slot.value;
      end
      if (lsb_hit) begin
        r.ready = TRUE;
        r.value = lsb_value;
      end
      if (alu_hit) begin
        r.ready = TRUE;
        r.value = alu_value;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Decode, query, write-back and commit signals of the reorder buffer.
// ROB_DUAL_CDB_EN adds the load/store write-back port.
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  logic     in_decode_ce;
  reg_tag_t in_decode_dest_reg;
  logic     in_decode_is_branch;
  logic     in_decode_pred_taken;
  rob_tag_t out_decode_rob_tag;
  logic     out_full;

  rob_tag_t in_decode_query_tag1;
  rob_tag_t in_decode_query_tag2;
  logic     out_decode_query_ready1;
  logic     out_decode_query_ready2;
  data_t    out_decode_query_value1;
  data_t    out_decode_query_value2;

  logic     in_cdb_valid;
  rob_tag_t in_cdb_tag;
  data_t    in_cdb_value;
  logic     in_cdb_taken;
  data_t    in_cdb_target;
`ifdef ROB_DUAL_CDB_EN
  logic     in_lsb_cdb_valid;
  rob_tag_t in_lsb_cdb_tag;
  data_t    in_lsb_cdb_value;
`endif

  reg_tag_t out_reg_commit_reg;
  rob_tag_t out_reg_commit_rob;
  data_t    out_reg_commit_value;
  logic     out_misbranch;
  data_t    out_fetcher_pc;

  // Handshake: no ready/valid backpressure; in_decode_ce is honoured only while
  // out_full is low, and commit/misbranch outputs are single-cycle pulses.
  modport slave (
`ifdef ROB_DUAL_CDB_EN
    input  in_lsb_cdb_valid, in_lsb_cdb_tag, in_lsb_cdb_value,
`endif
    input  in_decode_ce, in_decode_dest_reg, in_decode_is_branch, in_decode_pred_taken,
    input  in_decode_query_tag1, in_decode_query_tag2,
    input  in_cdb_valid, in_cdb_tag, in_cdb_value, in_cdb_taken, in_cdb_target,
    output out_decode_rob_tag, out_full,
    output out_decode_query_ready1, out_decode_query_ready2,
    output out_decode_query_value1, out_decode_query_value2,
    output out_reg_commit_reg, out_reg_commit_rob, out_reg_commit_value,
    output out_misbranch, out_fetcher_pc
  );

  modport master (
`ifdef ROB_DUAL_CDB_EN
    output in_lsb_cdb_valid, in_lsb_cdb_tag, in_lsb_cdb_value,
`endif
    output in_decode_ce, in_decode_dest_reg, in_decode_is_branch, in_decode_pred_taken,
    output in_decode_query_tag1, in_decode_query_tag2,
    output in_cdb_valid, in_cdb_tag, in_cdb_value, in_cdb_taken, in_cdb_target,
    input  out_decode_rob_tag, out_full,
    input  out_decode_query_ready1, out_decode_query_ready2,
    input  out_decode_query_value1, out_decode_query_value2,
    input  out_reg_commit_reg, out_reg_commit_rob, out_reg_commit_value,
    input  out_misbranch, out_fetcher_pc
  );

endinterface

// File: rtl/reorder_buffer_rob_ptr_wrap.sv
// Circular ROB pointer increment: 1 -> 2 -> ... -> ROB_SIZE-1 -> 1, slot 0 never used.
module reorder_buffer_rob_ptr_wrap
  import reorder_buffer_pkg::*;
(
  input  rob_tag_t ptr_i,
  output rob_tag_t ptr_nxt_o
);

  assign ptr_nxt_o = (ptr_i == LAST_TAG_ROB) ? FIRST_TAG_ROB : ptr_i + FIRST_TAG_ROB;

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: tag allocation, CDB capture, operand lookup, commit and mispredict flush.
// ROB_DUAL_CDB_EN enables the load/store write-back port (ALU port wins on equal tags).
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  reorder_buffer_if.slave  rob
);

  rob_entry_t entries_q [ROB_SIZE];
  rob_entry_t entries_d [ROB_SIZE];
  rob_tag_t   head_q, head_d, tail_q, tail_d, count_q, count_d;
  rob_tag_t   head_nxt, tail_nxt;

  reg_tag_t   commit_reg_q, commit_reg_d;
  rob_tag_t   commit_rob_q, commit_rob_d;
  data_t      commit_value_q, commit_value_d;
  logic       misbranch_q, misbranch_d;
  data_t      fetcher_pc_q, fetcher_pc_d;

  rob_entry_t head_ent;
  logic       full, alloc, commit, mispredict;
  logic       alu_hit1, alu_hit2, lsb_hit1, lsb_hit2;
  data_t      lsb_value;
  query_t     q1, q2;

  reorder_buffer_rob_ptr_wrap u_head_wrap (.ptr_i(head_q), .ptr_nxt_o(head_nxt));
  reorder_buffer_rob_ptr_wrap u_tail_wrap (.ptr_i(tail_q), .ptr_nxt_o(tail_nxt));

  assign head_ent   = entries_q[head_q];
  assign full       = (count_q == LAST_TAG_ROB);
  assign alloc      = rdy && rob.in_decode_ce && !full;
  // Uses the registered ready bit, so a same-cycle CDB write to head retires one cycle later.
  assign commit     = rdy && head_ent.valid && head_ent.ready;
  assign mispredict = commit && head_ent.is_branch && (head_ent.taken != head_ent.pred_taken);

  assign alu_hit1 = rob.in_cdb_valid && (rob.in_cdb_tag == rob.in_decode_query_tag1);
  assign alu_hit2 = rob.in_cdb_valid && (rob.in_cdb_tag == rob.in_decode_query_tag2);
`ifdef ROB_DUAL_CDB_EN
  assign lsb_hit1  = rob.in_lsb_cdb_valid && (rob.in_lsb_cdb_tag == rob.in_decode_query_tag1);
  assign lsb_hit2  = rob.in_lsb_cdb_valid && (rob.in_lsb_cdb_tag == rob.in_decode_query_tag2);
  assign lsb_value = rob.in_lsb_cdb_value;
`else
  assign lsb_hit1  = FALSE;
  assign lsb_hit2  = FALSE;
  assign lsb_value = ZERO_DATA;
`endif

  assign q1 = rob_lookup(rob.in_decode_query_tag1, entries_q[rob.in_decode_query_tag1],
                         alu_hit1, rob.in_cdb_value, lsb_hit1, lsb_value);
  assign q2 = rob_lookup(rob.in_decode_query_tag2, entries_q[rob.in_decode_query_tag2],
                         alu_hit2, rob.in_cdb_value, lsb_hit2, lsb_value);

  assign rob.out_decode_query_ready1 = q1.ready;
  assign rob.out_decode_query_value1 = q1.value;
  assign rob.out_decode_query_ready2 = q2.ready;
  assign rob.out_decode_query_value2 = q2.value;
  assign rob.out_decode_rob_tag      = tail_q;
  assign rob.out_full                = full;
  assign rob.out_reg_commit_reg      = commit_reg_q;
  assign rob.out_reg_commit_rob      = commit_rob_q;
  assign rob.out_reg_commit_value    = commit_value_q;
  assign rob.out_misbranch           = misbranch_q;
  assign rob.out_fetcher_pc          = fetcher_pc_q;

  always_comb begin
    entries_d      = entries_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    commit_reg_d   = ZERO_TAG_REG;
    commit_rob_d   = ZERO_TAG_ROB;
    commit_value_d = ZERO_DATA;
    misbranch_d    = FALSE;
    fetcher_pc_d   = ZERO_DATA;

`ifdef ROB_DUAL_CDB_EN
    if (rdy && rob.in_lsb_cdb_valid && entries_q[rob.in_lsb_cdb_tag].valid) begin
      entries_d[rob.in_lsb_cdb_tag].ready = TRUE;
      entries_d[rob.in_lsb_cdb_tag].value = rob.in_lsb_cdb_value;
    end
`endif
    if (rdy && rob.in_cdb_valid && entries_q[rob.in_cdb_tag].valid) begin
      entries_d[rob.in_cdb_tag].ready  = TRUE;
      entries_d[rob.in_cdb_tag].value  = rob.in_cdb_value;
      entries_d[rob.in_cdb_tag].taken  = rob.in_cdb_taken;
      entries_d[rob.in_cdb_tag].target = rob.in_cdb_target;
    end

    if (alloc) begin
      entries_d[tail_q].valid      = TRUE;
      entries_d[tail_q].ready      = FALSE;
      entries_d[tail_q].is_branch  = rob.in_decode_is_branch;
      entries_d[tail_q].pred_taken = rob.in_decode_pred_taken;
      entries_d[tail_q].taken      = FALSE;
      entries_d[tail_q].dest       = rob.in_decode_dest_reg;
      entries_d[tail_q].value      = ZERO_DATA;
      entries_d[tail_q].target     = ZERO_DATA;
      tail_d                       = tail_nxt;
    end

    if (commit) begin
      commit_reg_d            = head_ent.is_branch ? ZERO_TAG_REG : head_ent.dest;
      commit_rob_d            = head_q;
      commit_value_d          = head_ent.value;
      entries_d[head_q].valid = FALSE;
      entries_d[head_q].ready = FALSE;
      head_d                  = head_nxt;
    end

    case ({alloc, commit})
      2'b10:   count_d = count_q + FIRST_TAG_ROB;
      2'b01:   count_d = count_q - FIRST_TAG_ROB;
      default: count_d = count_q;
    endcase

    // A mispredict squashes every younger entry, including one allocated this cycle.
    if (mispredict) begin
      misbranch_d  = TRUE;
      fetcher_pc_d = head_ent.target;
      for (int i = 0; i < ROB_SIZE; i++) begin
        entries_d[i].valid = FALSE;
        entries_d[i].ready = FALSE;
      end
      head_d  = FIRST_TAG_ROB;
      tail_d  = FIRST_TAG_ROB;
      count_d = ZERO_TAG_ROB;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROB_SIZE; i++) entries_q[i] <= '0;
      head_q         <= FIRST_TAG_ROB;
      tail_q         <= FIRST_TAG_ROB;
      count_q        <= ZERO_TAG_ROB;
      commit_reg_q   <= ZERO_TAG_REG;
      commit_rob_q   <= ZERO_TAG_ROB;
      commit_value_q <= ZERO_DATA;
      misbranch_q    <= FALSE;
      fetcher_pc_q   <= ZERO_DATA;
    end else begin
      for (int i = 0; i < ROB_SIZE; i++) entries_q[i] <= entries_d[i];
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_reg_q   <= commit_reg_d;
      commit_rob_q   <= commit_rob_d;
      commit_value_q <= commit_value_d;
      misbranch_q    <= misbranch_d;
      fetcher_pc_q   <= fetcher_pc_d;
    end
  end

endmodule
